// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side blocks.
package fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_packer_timer.sv
// Idle counter for fifo_packer: pulses expire once idle has held for
// TimeoutCycles-1 consecutive cycles. Only used with FIFO_PACKER_TIMEOUT_EN.
module fifo_packer_timer
  import fifo_pkg::*;
#(
  parameter int TimeoutCycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle,
  output logic expire
);

  localparam int TW = idx_width(TimeoutCycles);

  logic [TW-1:0] count;

  assign expire = (count == TW'(TimeoutCycles - 1));

  // Stops at expiry; the flush it triggers leaves FILL, which drops idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                count <= '0;
    else if (idle && !expire) count <= count + TW'(1);
    else                      count <= '0;
  end

endmodule

// File: rtl/fifo_packer.sv
// Packs PackRatio FIFO words into one valid/ready beat with a lane keep mask.
// Define FIFO_PACKER_TIMEOUT_EN to auto-flush partial beats after an idle timeout.
module fifo_packer
  import fifo_pkg::*;
#(
  parameter int WordLength    = 8,
  parameter int PackRatio     = 4,
  parameter int TimeoutCycles = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            fifo_empty_i,
  input  logic [WordLength-1:0]           fifo_data_i,
  output logic                            fifo_rd_o,
  input  logic                            flush_i,
  output logic [WordLength*PackRatio-1:0] m_data_o,
  output logic [PackRatio-1:0]            m_keep_o,
  output logic                            m_valid_o,
  input  logic                            m_ready_i
);

  localparam int CW = idx_width(PackRatio);
  localparam logic [CW-1:0] LAST = CW'(PackRatio - 1);

  if (PackRatio < 2 || TimeoutCycles < 2) begin : g_bad_params
    $error("fifo_packer: PackRatio and TimeoutCycles must both be >= 2");
  end

  packer_state_e                        state, state_nxt;
  logic [CW-1:0]                        cnt, cnt_nxt;
  logic [PackRatio-1:0][WordLength-1:0] lanes, lanes_nxt;
  logic [PackRatio-1:0]                 keep, keep_nxt;
  logic                                 pop;
  logic                                 flush_req;

`ifdef FIFO_PACKER_TIMEOUT_EN
  logic expire;
  logic idle;

  assign idle      = (state == FILL) && (keep != '0) && !pop;
  assign flush_req = flush_i || expire;

  fifo_packer_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .idle   (idle),
    .expire (expire)
  );
`else
  assign flush_req = flush_i;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lanes_nxt = lanes;
    keep_nxt  = keep;
    pop       = 1'b0;
    case (state)
      FILL: begin
        pop = !fifo_empty_i;
        if (pop) begin
          lanes_nxt[cnt] = fifo_data_i;
          keep_nxt[cnt]  = 1'b1;
          if (cnt == LAST) state_nxt = HOLD;
          else             cnt_nxt   = cnt + CW'(1);
        end
        // keep_nxt already includes this cycle's pop, so it is flushed too.
        if (flush_req && (keep_nxt != '0)) state_nxt = HOLD;
      end
      HOLD: begin
        pop = m_ready_i && !fifo_empty_i;
        if (m_ready_i) begin
          state_nxt = FILL;
          lanes_nxt = '0;
          keep_nxt  = '0;
          cnt_nxt   = '0;
          if (pop) begin
            lanes_nxt[0] = fifo_data_i;
            keep_nxt[0]  = 1'b1;
            cnt_nxt      = CW'(1);
          end
        end
      end
      default: state_nxt = FILL;
    endcase
    if (rst_i) pop = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= FILL;
      cnt   <= '0;
      lanes <= '0;
      keep  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lanes <= lanes_nxt;
      keep  <= keep_nxt;
    end
  end

  assign fifo_rd_o = pop;
  assign m_data_o  = lanes;
  assign m_keep_o  = keep;
  assign m_valid_o = (state == HOLD);

endmodule

// File: tb/tb_fifo_packer.sv
// Scoreboard bench for fifo_packer (WordLength=8, PackRatio=4) with a behavioural FIFO.
module tb_fifo_packer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fifo_empty_i;
  logic [7:0]  fifo_data_i;
  logic        fifo_rd_o;
  logic        flush_i;
  logic [31:0] m_data_o;
  logic [3:0]  m_keep_o;
  logic        m_valid_o;
  logic        m_ready_i;

  logic [7:0]  mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  beat_t       exp_q[$];
  int          beat_cyc[$];

  fifo_packer #(
    .WordLength    (8),
    .PackRatio     (4),
    .TimeoutCycles (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_o    (fifo_rd_o),
    .flush_i      (flush_i),
    .m_data_o     (m_data_o),
    .m_keep_o     (m_keep_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i)
  );

  always #5 clk = ~clk;

  assign fifo_empty_i = (rd_ptr == wr_ptr);
  assign fifo_data_i  = mem[rd_ptr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_o) rd_ptr <= rd_ptr + 8'd1;
  end

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic void expect_beat(input logic [31:0] d, input logic [3:0] k);
    beat_t b;
    b.data = d;
    b.keep = k;
    exp_q.push_back(b);
  endfunction

  // Monitor: every accepted beat is matched against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (fifo_rd_o && fifo_empty_i) begin
      compared++;
      mismatched++;
      $display("FAIL rd_while_empty: got fifo_rd_o=1 expected 0 (cycle %0d)", cyc);
    end
    if (!rst_i && m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_beat: got data=%h keep=%h expected no beat (cycle %0d)",
                 m_data_o, m_keep_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", m_data_o, e.data);
        check("beat_keep", {28'd0, m_keep_o}, {28'd0, e.keep});
      end
      beat_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!m_valid_o && n < 60) begin
      tick(1);
      n++;
    end
    if (!m_valid_o) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got no m_valid_o expected a beat within 60 cycles", nm);
    end
  endtask

  initial begin
    int n0;
    int n;
    rst_i     = 1'b1;
    flush_i   = 1'b0;
    m_ready_i = 1'b0;
    tick(2);

    // Reset state; words waiting in the FIFO must not be popped during reset.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    check("rst_rd",    {31'd0, fifo_rd_o}, 32'd0);
    check("rst_valid", {31'd0, m_valid_o}, 32'd0);
    check("rst_data",  m_data_o, 32'd0);
    check("rst_keep",  {28'd0, m_keep_o}, 32'd0);

    // 1. Full beat, valid for exactly one cycle.
    expect_beat(32'h44332211, 4'hF);
    tick(1);
    rst_i     = 1'b0;
    m_ready_i = 1'b1;
    wait_valid("full_beat");
    tick(1);
    check("single_cycle_valid", {31'd0, m_valid_o}, 32'd0);

    // 2. Streaming: three beats, four cycles apart.
    n0 = beat_cyc.size();
    for (int i = 0; i < 12; i++) push(8'(i));
    expect_beat(32'h03020100, 4'hF);
    expect_beat(32'h07060504, 4'hF);
    expect_beat(32'h0B0A0908, 4'hF);
    tick(20);
    check("stream_beats", beat_cyc.size() - n0, 32'd3);
    if (beat_cyc.size() - n0 >= 3) begin
      check("stream_gap0", beat_cyc[n0+1] - beat_cyc[n0],   32'd4);
      check("stream_gap1", beat_cyc[n0+2] - beat_cyc[n0+1], 32'd4);
    end

    // 3. Backpressure: beat held stable, no popping until release.
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
    expect_beat(32'hA3A2A1A0, 4'hF);
    expect_beat(32'hB3B2B1B0, 4'hF);
    expect_beat(32'h000000B4, 4'h1);
    wait_valid("bp_beat");
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_data",  m_data_o, 32'hA3A2A1A0);
      check("bp_rd",    {31'd0, fifo_rd_o}, 32'd0);
      check("bp_valid", {31'd0, m_valid_o}, 32'd1);
    end
    m_ready_i = 1'b1;
    #1;
    check("release_pop", {31'd0, fifo_rd_o}, 32'd1);
    tick(10);
    pulse_flush();
    tick(5);

    // 4. Flush: partial beat, empty accumulator, flush coincident with a pop.
    push(8'hAA); push(8'hBB);
    expect_beat(32'h0000BBAA, 4'h3);
    tick(4);
    pulse_flush();
    tick(4);
    pulse_flush();
    tick(4);
    check("empty_flush", {31'd0, m_valid_o}, 32'd0);
    push(8'hAA); push(8'hBB);
    expect_beat(32'h00CCBBAA, 4'h7);
    tick(4);
    push(8'hCC);
    pulse_flush();
    tick(4);

    // 5. Idle timeout.
    push(8'h5A);
    expect_beat(32'h0000005A, 4'h1);
    tick(1);
`ifdef FIFO_PACKER_TIMEOUT_EN
    n = 0;
    while (!m_valid_o && n < 40) begin
      tick(1);
      n++;
    end
    check("timeout_latency", n, 32'd16);
    tick(2);
`else
    n = 0;
    tick(40);
    check("no_timeout", {31'd0, m_valid_o}, 32'd0);
    pulse_flush();
    tick(2);
`endif

    // 6. Asynchronous reset mid-pack discards the partial beat.
    push(8'h61); push(8'h62);
    tick(2);
    check("pre_reset_data", m_data_o, 32'h00006261);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_valid", {31'd0, m_valid_o}, 32'd0);
    check("arst_data",  m_data_o, 32'd0);
    check("arst_keep",  {28'd0, m_keep_o}, 32'd0);
    for (int i = 0; i < 4; i++) push(8'h71 + 8'(i));
    #1;
    check("arst_rd", {31'd0, fifo_rd_o}, 32'd0);
    expect_beat(32'h74737271, 4'hF);
    tick(1);
    rst_i = 1'b0;
    tick(10);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_packer.md
# fifo_packer

Downstream consumer of the FIFO's read port. Pops `WordLength`-bit words through the FIFO's combinational read interface, packs `PackRatio` consecutive words into one wide beat, and presents the beat on a valid/ready stream. Partial beats can be emitted on request, and optionally on an idle timeout; a per-lane keep mask marks which lanes hold data. Typical use is width-upsizing between the FIFO and a wide bus master.

## Interface
- `WordLength`, default 8: FIFO word width, one lane.
- `PackRatio`, default 4: lanes per output beat; must be ≥2.
- `TimeoutCycles`, default 16: idle cycles before a partial beat is auto-flushed; ≥2. Used only with `FIFO_PACKER_TIMEOUT_EN`.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous reset, active-high.
- `fifo_empty_i` in 1: FIFO empty flag.
- `fifo_data_i` in `WordLength`: FIFO head word, valid combinationally while `fifo_empty_i`=0.
- `fifo_rd_o` out 1: pop strobe to the FIFO; the word is consumed at the same edge.
- `flush_i` in 1: emit the current partial beat.
- `m_data_o` out `WordLength*PackRatio`: packed beat; lane i is `[i*WordLength +: WordLength]`, lane 0 = first word popped.
- `m_keep_o` out `PackRatio`: bit i=1 means lane i is valid; always contiguous from lane 0.
- `m_valid_o` out 1: beat valid.
- `m_ready_i` in 1: sink accepts the beat.

## Operation
- Two states:
  - FILL: accumulating words.
  - HOLD: full or flushed beat presented.
- Lane counter `cnt` runs 0..PackRatio-1 and is valid only in FILL.
- `fifo_rd_o` is combinational:
  - FILL: `!fifo_empty_i`.
  - HOLD: `m_ready_i && !fifo_empty_i` (the pop overlaps the handshake).
  - Forced to 0 while `rst_i`=1.
  - Never asserted while empty.
- Pop in FILL:
  - Capture `fifo_data_i` into lane `cnt` and set `keep[cnt]`.
  - If `cnt`==PackRatio-1, go to HOLD. Otherwise increment `cnt`.
- Flush in FILL:
  - Condition: `flush_i`=1 and at least one lane is occupied after this cycle's pop.
  - Go to HOLD with the partial keep mask. A same-cycle pop is captured first, then flushed.
  - If no lane is occupied and there is no pop, `flush_i` is ignored.
  - `flush_i` is always ignored in HOLD.
- HOLD:
  - `m_valid_o`=1. `m_data_o` and `m_keep_o` stay stable until `m_ready_i`=1.
  - On handshake, all lanes and keep bits clear to 0 and `cnt`=0.
  - A same-cycle pop loads lane 0 (keep=0…01, `cnt`=1) and the next state is FILL.
  - With PackRatio=1-deep data this cannot re-enter HOLD; PackRatio≥2 guarantees it.
- Lanes not written in a partial beat read as zero.
- Reset mid-operation discards partially packed data. Words already popped are lost, which is the intended behaviour.

## Timing
- Reset values:
  - `m_valid_o`=0, `m_data_o`=0, `m_keep_o`=0, `fifo_rd_o`=0.
  - State FILL, `cnt`=0, timeout counter 0.
- `m_data_o`, `m_keep_o` and `m_valid_o` are registered.
- `fifo_rd_o` is the only combinational output. Paths into it: `fifo_empty_i` and `m_ready_i`.
- Latency: `m_valid_o` rises the cycle after the edge that captured the last lane or registered the flush.
- Sustained throughput: one beat per PackRatio cycles when the FIFO is never empty and `m_ready_i`=1 (no bubble).
- `m_valid_o` never drops without a handshake. Backpressure holds the beat and stalls popping.

## Configuration
- Macro `FIFO_PACKER_TIMEOUT_EN`:
  - **Defined:** an idle counter increments each FILL cycle with ≥1 occupied lane and no pop, and clears on any pop or on leaving FILL. When it reaches TimeoutCycles-1, the block behaves exactly as `flush_i`=1.
  - **Not defined:** the counter is absent, `TimeoutCycles` is unused, and partial beats leave only via `flush_i`.

## Structure
- Shared package `fifo_pkg` holds:
  - `packer_state_e` enum {FILL, HOLD}.
  - Lane-index width constant helper `$clog2(PackRatio)`.
- Sub-module `fifo_packer_timer` (idle counter plus expire pulse) is instantiated only under `FIFO_PACKER_TIMEOUT_EN`.
- Packing datapath and FSM stay in `fifo_packer`.

## Test plan
All scenarios use WordLength=8, PackRatio=4.

1. **Full beat.** Push 0x11, 0x22, 0x33, 0x44 into the FIFO with `m_ready_i`=1 → one beat, `m_data_o`=0x44332211, `m_keep_o`=0xF, `m_valid_o` high for exactly 1 cycle.
2. **Streaming, no bubbles.** Push 12 words 0x00..0x0B continuously with `m_ready_i`=1 → 3 beats 0x03020100, 0x07060504, 0x0B0A0908 on cycles spaced exactly 4 apart.
3. **Backpressure.** Hold `m_ready_i`=0 for 10 cycles after a beat forms while the FIFO holds 5 more words → data stable, `fifo_rd_o`=0 throughout. On release, the next word is popped in the handshake cycle and the next beat is correct.
4. **Flush.**
   - Push 0xAA, 0xBB, then pulse `flush_i` → `m_data_o`=0x0000BBAA, `m_keep_o`=0x3.
   - Flush with an empty accumulator → no beat.
   - Flush coincident with the pop of 0xCC after 0xAA, 0xBB → keep=0x7.
5. **Timeout** (macro defined, TimeoutCycles=16). Push one word 0x5A and nothing more → beat 0x0000005A, keep=0x1, `m_valid_o` rises 16 cycles after the pop. Without the macro, no beat appears.
6. **Reset mid-pack.** Assert `rst_i` asynchronously after 2 pops → all outputs 0 immediately. After release, the next 4 words form a clean beat with keep=0xF.
